// File: rtl/alu_pkg.sv
// Shared encodings for the 8-bit ALU issuing sequencer.
// Holds selector codes, flag bit positions, FSM state codes and small opcode helpers.
// No ports; imported by alu_flag_gen and alu_op_sequencer.
package alu_pkg;

  localparam int FLAGS_W = 5;

  // ALU selector / request opcodes
  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_SUB = 4'b0001;
  localparam logic [3:0] SEL_AND = 4'b0010;
  localparam logic [3:0] SEL_OR  = 4'b0011;
  localparam logic [3:0] SEL_XOR = 4'b0100;
  localparam logic [3:0] SEL_NOT = 4'b0101;

  // Flag bit positions inside {OF,SF,ZF,PF,CF}
  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 1;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_SF = 3;
  localparam int FLAG_OF = 4;

  // Sequencer FSM states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op <= SEL_NOT);
  endfunction

  function automatic logic op_is_arith(input logic [3:0] op);
    return (op == SEL_ADD) || (op == SEL_SUB);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Purpose: derives {OF,SF,ZF,PF,CF} for a finished 8- or 16-bit result.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: result_i/wide_i/op_i describe the result; c_lo_i/o_lo_i are the low-byte
//   ALU carry/overflow, c_hi_i the merged high-byte carry, a_msb_i/b_msb_i the
//   operand sign bits used for 16-bit overflow; flags_o is the flag vector.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [15:0]        result_i,
  input  logic               wide_i,
  input  logic [3:0]         op_i,
  input  logic               c_lo_i,
  input  logic               o_lo_i,
  input  logic               c_hi_i,
  input  logic               a_msb_i,
  input  logic               b_msb_i,
  output logic [FLAGS_W-1:0] flags_o
);

  logic r_msb;

  always_comb begin
    flags_o = '0;
    r_msb   = wide_i ? result_i[15] : result_i[7];

    flags_o[FLAG_PF] = ~^result_i[7:0];
    flags_o[FLAG_ZF] = wide_i ? (result_i == 16'h0000) : (result_i[7:0] == 8'h00);
    flags_o[FLAG_SF] = r_msb;

    if (op_is_arith(op_i)) begin
      if (wide_i) begin
        flags_o[FLAG_CF] = c_hi_i;
        // The 8-bit ALU only sees byte slices, so 16-bit overflow is rebuilt
        // from the full-width operand and result sign bits.
        if (op_i == SEL_ADD) begin
          flags_o[FLAG_OF] = (a_msb_i == b_msb_i) && (r_msb != a_msb_i);
        end else begin
          flags_o[FLAG_OF] = (a_msb_i != b_msb_i) && (r_msb != a_msb_i);
        end
      end else begin
        flags_o[FLAG_CF] = c_lo_i;
        flags_o[FLAG_OF] = o_lo_i;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: issues 8/16-bit requests to an 8-bit ALU in byte passes and returns result+flags.
// Latency: accept->rsp_valid 2 cycles (8-bit), 3 (16-bit), 4 (16-bit with carry/borrow fix).
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
// Ports: clk/rst (sync active-high); req_* request handshake and operands;
//   alu_a/alu_b/alu_sel registered ALU drive, alu_x/alu_cout/alu_oflow ALU returns;
//   rsp_* response handshake, result and error; flags architectural {OF,SF,ZF,PF,CF}.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic               req_wide,
  input  logic [15:0]        req_a,
  input  logic [15:0]        req_b,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_sel,
  input  logic [7:0]         alu_x,
  input  logic               alu_cout,
  input  logic               alu_oflow,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_result,
  output logic               rsp_err,
  output logic [FLAGS_W-1:0] flags
);

  logic [2:0]         state_q,  state_d;
  logic [3:0]         op_q,     op_d;
  logic               wide_q,   wide_d;
  logic [7:0]         a_hi_q,   a_hi_d;
  logic [7:0]         b_hi_q,   b_hi_d;
  logic [7:0]         x_lo_q,   x_lo_d;
  logic               c0_q,     c0_d;
  logic               o0_q,     o0_d;
  logic               c1_q,     c1_d;
  logic [7:0]         alu_a_q,  alu_a_d;
  logic [7:0]         alu_b_q,  alu_b_d;
  logic [3:0]         alu_sel_q, alu_sel_d;
  logic               rsp_valid_q,  rsp_valid_d;
  logic [15:0]        rsp_result_q, rsp_result_d;
  logic               rsp_err_q,    rsp_err_d;
  logic [FLAGS_W-1:0] flags_q,  flags_d;

  // Operands of the pass that completes the operation, fed to the flag generator.
  logic [15:0]        fin_result;
  logic               fin_c_lo;
  logic               fin_o_lo;
  logic               fin_c_hi;
  logic               load_rsp;
  logic [FLAGS_W-1:0] fin_flags;

  alu_flag_gen u_flag_gen (
    .result_i (fin_result),
    .wide_i   (wide_q),
    .op_i     (op_q),
    .c_lo_i   (fin_c_lo),
    .o_lo_i   (fin_o_lo),
    .c_hi_i   (fin_c_hi),
    .a_msb_i  (a_hi_q[7]),
    .b_msb_i  (b_hi_q[7]),
    .flags_o  (fin_flags)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wide_d       = wide_q;
    a_hi_d       = a_hi_q;
    b_hi_d       = b_hi_q;
    x_lo_d       = x_lo_q;
    c0_d         = c0_q;
    o0_d         = o0_q;
    c1_d         = c1_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    flags_d      = flags_q;
    fin_result   = 16'h0000;
    fin_c_lo     = c0_q;
    fin_o_lo     = o0_q;
    fin_c_hi     = 1'b0;
    load_rsp     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          wide_d = req_wide;
          a_hi_d = req_a[15:8];
          b_hi_d = req_b[15:8];
          if (!op_is_valid(req_op)) begin
            // Bad opcode never touches the ALU or the flags register.
            state_d      = S_DONE;
            rsp_valid_d  = 1'b1;
            rsp_result_d = 16'h0000;
            rsp_err_d    = 1'b1;
          end else begin
            alu_a_d   = req_a[7:0];
            alu_b_d   = req_b[7:0];
            alu_sel_d = req_op;
            state_d   = S_LO;
          end
        end
      end

      S_LO: begin
        x_lo_d   = alu_x;
        c0_d     = alu_cout;
        o0_d     = alu_oflow;
        fin_c_lo = alu_cout;
        fin_o_lo = alu_oflow;
        if (!wide_q) begin
          fin_result = {8'h00, alu_x};
          load_rsp   = 1'b1;
        end else begin
          alu_a_d = a_hi_q;
          alu_b_d = b_hi_q;
          state_d = S_HI;
        end
      end

      S_HI: begin
        c1_d = alu_cout;
        // A low-byte carry/borrow is folded into the high byte with a second
        // +1/-1 pass using the same selector.
        if (c0_q && op_is_arith(op_q)) begin
          alu_a_d = alu_x;
          alu_b_d = 8'h01;
          state_d = S_FIX;
        end else begin
          fin_result = {alu_x, x_lo_q};
          fin_c_hi   = alu_cout;
          load_rsp   = 1'b1;
        end
      end

      S_FIX: begin
        fin_result = {alu_x, x_lo_q};
        fin_c_hi   = c1_q | alu_cout;
        load_rsp   = 1'b1;
      end

      S_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load_rsp) begin
      state_d      = S_DONE;
      rsp_valid_d  = 1'b1;
      rsp_result_d = fin_result;
      rsp_err_d    = 1'b0;
      flags_d      = fin_flags;
      alu_a_d      = 8'h00;
      alu_b_d      = 8'h00;
      alu_sel_d    = SEL_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 4'h0;
      wide_q       <= 1'b0;
      a_hi_q       <= 8'h00;
      b_hi_q       <= 8'h00;
      x_lo_q       <= 8'h00;
      c0_q         <= 1'b0;
      o0_q         <= 1'b0;
      c1_q         <= 1'b0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_sel_q    <= SEL_ADD;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 16'h0000;
      rsp_err_q    <= 1'b0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wide_q       <= wide_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      x_lo_q       <= x_lo_d;
      c0_q         <= c0_d;
      o0_q         <= o0_d;
      c1_q         <= c1_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      flags_q      <= flags_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural 8-bit ALU attached to its ALU port.
// Directed scenarios, each task checking its own hand-computed expectations.
// Flags are written as {OF,SF,ZF,PF,CF}.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_wide;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_x;
  logic        alu_cout;
  logic        alu_oflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;
  int lat;
  logic tmo;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_wide   (req_wide),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_x      (alu_x),
    .alu_cout   (alu_cout),
    .alu_oflow  (alu_oflow),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .flags      (flags)
  );

  // Behavioural 8-bit ALU: cout is carry for ADD, borrow for SUB.
  always_comb begin
    logic [8:0] sum;
    sum       = 9'h000;
    alu_x     = 8'h00;
    alu_cout  = 1'b0;
    alu_oflow = 1'b0;
    case (alu_sel)
      4'b0000: begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_x     = sum[7:0];
        alu_cout  = sum[8];
        alu_oflow = (alu_a[7] == alu_b[7]) && (alu_x[7] != alu_a[7]);
      end
      4'b0001: begin
        alu_x     = alu_a - alu_b;
        alu_cout  = (alu_a < alu_b);
        alu_oflow = (alu_a[7] != alu_b[7]) && (alu_x[7] != alu_a[7]);
      end
      4'b0010: alu_x = alu_a & alu_b;
      4'b0011: alu_x = alu_a | alu_b;
      4'b0100: alu_x = alu_a ^ alu_b;
      4'b0101: alu_x = ~alu_a;
      default: alu_x = 8'h00;
    endcase
  end

  // Presents one request in IDLE and measures edges from the accepting edge
  // (counted as 1) until rsp_valid is seen; tmo flags a missing response.
  task automatic issue(input logic [3:0] op, input logic wide,
                       input logic [15:0] a, input logic [15:0] b,
                       output int latency, output logic timed_out);
    req_op    = op;
    req_wide  = wide;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    latency   = 1;
    while (!rsp_valid && latency < 20) begin
      @(posedge clk); #1;
      latency++;
    end
    timed_out = !rsp_valid;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: req_ready=%b rsp_valid=%b rsp_err=%b want 1 0 0", req_ready, rsp_valid, rsp_err);
    end
    checks++;
    if (rsp_result !== 16'h0000 || flags !== 5'b00000) begin
      failures++;
      $display("FAIL reset_data: result=%h flags=%b want 0000 00000", rsp_result, flags);
    end
    checks++;
    if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 4'b0000) begin
      failures++;
      $display("FAIL reset_alu: a=%h b=%h sel=%b want 00 00 0000", alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_add8();
    issue(4'b0000, 1'b0, 16'h007F, 16'h0001, lat, tmo);
    checks++;
    if (tmo || lat !== 2) begin
      failures++;
      $display("FAIL add8_latency: got %0d timeout=%b want 2", lat, tmo);
    end
    checks++;
    if (rsp_result !== 16'h0080 || rsp_err !== 1'b0 || flags !== 5'b11000) begin
      failures++;
      $display("FAIL add8_result: result=%h err=%b flags=%b want 0080 0 11000", rsp_result, rsp_err, flags);
    end
    checks++;
    if (alu_sel !== 4'b0000 || alu_a !== 8'h00 || alu_b !== 8'h00 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL add8_done_idle_alu: sel=%b a=%h b=%h req_ready=%b want 0000 00 00 0", alu_sel, alu_a, alu_b, req_ready);
    end
    ack();
  endtask

  task automatic test_add16_fix();
    issue(4'b0000, 1'b1, 16'h00FF, 16'h0001, lat, tmo);
    checks++;
    if (tmo || lat !== 4) begin
      failures++;
      $display("FAIL add16_fix_latency: got %0d timeout=%b want 4", lat, tmo);
    end
    checks++;
    if (rsp_result !== 16'h0100 || flags !== 5'b00010) begin
      failures++;
      $display("FAIL add16_fix_result: result=%h flags=%b want 0100 00010", rsp_result, flags);
    end
    ack();
  endtask

  task automatic test_add16_wrap();
    issue(4'b0000, 1'b1, 16'hFFFF, 16'h0001, lat, tmo);
    checks++;
    if (tmo || lat !== 4) begin
      failures++;
      $display("FAIL add16_wrap_latency: got %0d timeout=%b want 4", lat, tmo);
    end
    checks++;
    if (rsp_result !== 16'h0000 || flags !== 5'b00111) begin
      failures++;
      $display("FAIL add16_wrap_result: result=%h flags=%b want 0000 00111", rsp_result, flags);
    end
    ack();
  endtask

  task automatic test_sub16();
    issue(4'b0001, 1'b1, 16'h0000, 16'h0001, lat, tmo);
    checks++;
    if (tmo || lat !== 4) begin
      failures++;
      $display("FAIL sub16_latency: got %0d timeout=%b want 4", lat, tmo);
    end
    checks++;
    if (rsp_result !== 16'hFFFF || flags !== 5'b01011) begin
      failures++;
      $display("FAIL sub16_result: result=%h flags=%b want ffff 01011", rsp_result, flags);
    end
    ack();
  endtask

  task automatic test_xor16();
    issue(4'b0100, 1'b1, 16'hF0F0, 16'hFFFF, lat, tmo);
    checks++;
    if (tmo || lat !== 3) begin
      failures++;
      $display("FAIL xor16_latency: got %0d timeout=%b want 3", lat, tmo);
    end
    checks++;
    if (rsp_result !== 16'h0F0F || flags !== 5'b00010) begin
      failures++;
      $display("FAIL xor16_result: result=%h flags=%b want 0f0f 00010", rsp_result, flags);
    end
    ack();
  endtask

  task automatic test_back_to_back_hold();
    // 8-bit SUB 0x10-0x20 = 0xF0 with borrow; a second request waits behind it.
    issue(4'b0001, 1'b0, 16'h0010, 16'h0020, lat, tmo);
    checks++;
    if (tmo || lat !== 2 || rsp_result !== 16'h00F0 || flags !== 5'b01011) begin
      failures++;
      $display("FAIL sub8_result: lat=%0d result=%h flags=%b want 2 00f0 01011", lat, rsp_result, flags);
    end
    req_op    = 4'b0011;
    req_wide  = 1'b0;
    req_a     = 16'h00AA;
    req_b     = 16'h0055;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== 16'h00F0 || flags !== 5'b01011) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid=%b req_ready=%b result=%h flags=%b want 1 0 00f0 01011", i, rsp_valid, req_ready, rsp_result, flags);
      end
    end
    req_valid = 1'b0;
    ack();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_and8();
    // Upper bytes must be ignored for 8-bit ops.
    issue(4'b0010, 1'b0, 16'hAB3C, 16'h12F0, lat, tmo);
    checks++;
    if (tmo || lat !== 2 || rsp_result !== 16'h0030 || flags !== 5'b00010) begin
      failures++;
      $display("FAIL and8_result: lat=%0d result=%h flags=%b want 2 0030 00010", lat, rsp_result, flags);
    end
    ack();
  endtask

  task automatic test_invalid();
    issue(4'b1010, 1'b1, 16'h1234, 16'h5678, lat, tmo);
    checks++;
    if (tmo || rsp_err !== 1'b1 || rsp_result !== 16'h0000) begin
      failures++;
      $display("FAIL invalid_err: timeout=%b err=%b result=%h want 0 1 0000", tmo, rsp_err, rsp_result);
    end
    checks++;
    if (flags !== 5'b00010) begin
      failures++;
      $display("FAIL invalid_flags: flags=%b want 00010", flags);
    end
    ack();
  endtask

  task automatic test_reset_mid_op();
    req_op    = 4'b0000;
    req_wide  = 1'b1;
    req_a     = 16'hFFFF;
    req_b     = 16'h0001;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    // Now in HI: high bytes on the ALU port.
    checks++;
    if (alu_a !== 8'hFF || alu_b !== 8'h00 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_hi_drive: a=%h b=%h valid=%b want ff 00 0", alu_a, alu_b, rsp_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || flags !== 5'b00000 || alu_sel !== 4'b0000 || alu_a !== 8'h00) begin
      failures++;
      $display("FAIL midop_reset: req_ready=%b valid=%b flags=%b sel=%b a=%h want 1 0 00000 0000 00", req_ready, rsp_valid, flags, alu_sel, alu_a);
    end
    issue(4'b0011, 1'b0, 16'h000F, 16'h00F0, lat, tmo);
    checks++;
    if (tmo || lat !== 2 || rsp_result !== 16'h00FF || flags !== 5'b01010) begin
      failures++;
      $display("FAIL or8_after_reset: lat=%0d result=%h flags=%b want 2 00ff 01010", lat, rsp_result, flags);
    end
    ack();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 4'h0;
    req_wide  = 1'b0;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    rsp_ready = 1'b0;
    test_reset();
    test_add8();
    test_add16_fix();
    test_add16_wrap();
    test_sub16();
    test_xor16();
    test_back_to_back_hold();
    test_and8();
    test_invalid();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
